// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter: TDATA pushes bytes into a circular FIFO,
// TCTRL exposes ready/idle/overrun status and the interrupt enable.
module uart_tx_device #(
    parameter int              BITS    = 32,
    parameter logic [BITS-1:0] BASE    = 32'hF0000030,
    parameter int              DIV     = 434,
    parameter int              FIFO_AW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    input  logic            FLUSH,
    output logic            TXD,
    output logic            INTR
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int CW     = FIFO_AW + 1;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BITS-1:0]    CTRL_ADDR  = BASE + BITS'(32'h100);
    localparam logic [CW-1:0]      FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0]      COUNT_ONE  = CW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(DIV - 1);
    localparam logic [BAUD_W-1:0]  BAUD_ONE   = BAUD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          idx_reg, idx_next;
    logic [7:0]          shift_reg, shift_next;
    logic                txd_reg, txd_next;
    logic                intr_reg;
    logic [CW-1:0]       count_reg;
    logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic                ovr_reg, ie_reg;
    logic [7:0]          fifo_mem [DEPTH];

    logic                hit_d, hit_c;
    logic                wr_data, wr_ctrl;
    logic                ready, idle_flag, fifo_empty;
    logic                pop, push, drop;
    logic                baud_done;
    logic [BITS-1:0]     rdata;
    logic                unused_dbus;

    // Bus decode; FLUSH squashes every side effect of the current bus cycle.
    assign hit_d   = (ABUS == BASE);
    assign hit_c   = (ABUS == CTRL_ADDR);
    assign wr_data = WE & ~FLUSH & hit_d;
    assign wr_ctrl = WE & ~FLUSH & hit_c;

    assign fifo_empty = (count_reg == '0);
    assign ready      = (count_reg != FULL_COUNT);
    assign idle_flag  = (state_reg == ST_IDLE) && fifo_empty;

    // A full FIFO still accepts a byte when the serializer frees a slot this edge.
    assign pop  = (state_reg == ST_IDLE) && !fifo_empty;
    assign push = wr_data && (ready || pop);
    assign drop = wr_data && !push;

    assign baud_done = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_START;
                    baud_next  = '0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_next = ST_DATA;
                    baud_next  = '0;
                    idx_next   = '0;
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        idx_next   = idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    state_next = ST_IDLE;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
            end
        endcase
    end

    // TXD is derived from the upcoming state so the registered line changes on the same edge.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            ST_START: txd_next = 1'b0;
            ST_DATA:  txd_next = shift_next[0];
            default:  txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            baud_reg   <= '0;
            idx_reg    <= '0;
            shift_reg  <= '0;
            txd_reg    <= 1'b1;
            intr_reg   <= 1'b0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovr_reg    <= 1'b0;
            ie_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            idx_reg   <= idx_next;
            txd_reg   <= txd_next;
            intr_reg  <= ie_reg & ready;

            if (pop) begin
                shift_reg  <= fifo_mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end else begin
                shift_reg <= shift_next;
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase

            if (drop) begin
                ovr_reg <= 1'b1;
            end else if (wr_ctrl && !DBUS[2]) begin
                ovr_reg <= 1'b0;
            end

            if (wr_ctrl) begin
                ie_reg <= DBUS[8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= DBUS[7:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_c) begin
            rdata[0] = ready;
            rdata[1] = idle_flag;
            rdata[2] = ovr_reg;
            rdata[8] = ie_reg;
        end else begin
            rdata[CW-1:0] = count_reg;
        end
    end

    assign DBUS = (!WE && (hit_d || hit_c)) ? rdata : {BITS{1'bz}};

    assign TXD  = txd_reg;
    assign INTR = intr_reg;

    assign unused_dbus = ^DBUS[BITS-1:9];

endmodule

// File: tb/tb_uart_tx_device.sv
// Directed bench for uart_tx_device: a queue-based line/FIFO model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_uart_tx_device;
    localparam int          DIV       = 4;
    localparam logic [31:0] BASE      = 32'hF0000030;
    localparam logic [31:0] CTRL      = 32'hF0000130;
    localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ABUS = IDLE_ADDR;
    logic        WE = 1'b0;
    logic        FLUSH = 1'b0;
    logic        tb_drive = 1'b0;
    logic [31:0] tb_data = 32'h0;
    wire  [31:0] DBUS;
    wire         TXD;
    wire         INTR;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    assign DBUS = tb_drive ? tb_data : {32{1'bz}};

    uart_tx_device #(.BITS(32), .BASE(BASE), .DIV(DIV), .FIFO_AW(3)) dut (
        .clk(clk), .reset(reset), .ABUS(ABUS), .DBUS(DBUS),
        .WE(WE), .FLUSH(FLUSH), .TXD(TXD), .INTR(INTR)
    );

    always #5 clk = ~clk;

    // Model: FIFO of bytes plus a queue of line levels, one entry per bit-cycle.
    logic [7:0] m_fifo[$];
    logic       m_wave[$];
    logic       m_busy = 1'b0;
    logic       m_txd = 1'b1;
    logic       m_intr = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ie = 1'b0;

    task automatic model_step();
        int         cnt;
        logic       pop, wr_d, wr_c, push;
        logic [9:0] frame;
        logic [7:0] b;
        if (reset) begin
            m_fifo.delete();
            m_wave.delete();
            m_busy = 1'b0;
            m_txd  = 1'b1;
            m_intr = 1'b0;
            m_ovr  = 1'b0;
            m_ie   = 1'b0;
            return;
        end
        cnt  = m_fifo.size();
        pop  = !m_busy && (cnt > 0);
        wr_d = WE && !FLUSH && (ABUS == BASE);
        wr_c = WE && !FLUSH && (ABUS == CTRL);
        push = wr_d && ((cnt < 8) || pop);
        m_intr = m_ie && (cnt < 8);
        if (wr_d && !push) m_ovr = 1'b1;
        if (wr_c) begin
            m_ie = tb_data[8];
            if (!tb_data[2]) m_ovr = 1'b0;
        end
        if (pop) begin
            b = m_fifo.pop_front();
            frame = {1'b1, b, 1'b0};
            for (int n = 0; n < 10; n++)
                for (int r = 0; r < DIV; r++)
                    m_wave.push_back(frame[n]);
        end
        if (push) m_fifo.push_back(tb_data[7:0]);
        if (m_wave.size() > 0) begin
            m_txd  = m_wave.pop_front();
            m_busy = 1'b1;
        end else begin
            m_txd  = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a == CTRL) begin
            r[0] = (m_fifo.size() < 8);
            r[1] = !m_busy && (m_fifo.size() == 0);
            r[2] = m_ovr;
            r[8] = m_ie;
        end else begin
            r = 32'(m_fifo.size());
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("txd_cycle", {31'h0, TXD}, {31'h0, m_txd});
            check("intr_cycle", {31'h0, INTR}, {31'h0, m_intr});
            if (!tb_drive) begin
                vectors++;
                if (!((DBUS === {32{1'bz}}) || (DBUS === 32'h0))) begin
                    miscompares++;
                    $display("FAIL dbus_idle: got 0x%0h, expected Z at %0t", DBUS, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic fl);
        ABUS = a; tb_data = d; tb_drive = 1'b1; WE = 1'b1; FLUSH = fl;
        @(posedge clk); #1;
        $display("wr addr=%08h data=%08h flush=%0b", a, d, fl);
        WE = 1'b0; tb_drive = 1'b0; FLUSH = 1'b0; ABUS = IDLE_ADDR;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        ABUS = a; WE = 1'b0;
        #1;
        d = DBUS;
        $display("rd addr=%08h data=%08h", a, d);
        check("read_model", d, model_read(a));
        ABUS = IDLE_ADDR;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Called right after the accepting write; levels[n] is the line level of bit-slot n.
    task automatic frame_check(input string name, input logic [9:0] levels);
        logic [31:0] d;
        @(negedge clk);
        check({name, "_pre_fall"}, {31'h0, TXD}, 32'h1);
        for (int n = 0; n < 10 * DIV; n++) begin
            @(negedge clk);
            if ((n % DIV) == 2) check({name, "_bit"}, {31'h0, TXD}, {31'h0, levels[n / DIV]});
        end
        bus_read(CTRL, d);
        check({name, "_idle_at_40"}, d, 32'h001);
        @(negedge clk);
        bus_read(CTRL, d);
        check({name, "_idle_at_41"}, d, 32'h003);
    endtask

    initial begin
        logic [31:0] d;
        logic        seen;

        // 1: reset state
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        bus_read(CTRL, d);
        check("reset_tctrl", d, 32'h003);
        bus_read(BASE, d);
        check("reset_count", d, 32'h0);
        check("reset_txd", {31'h0, TXD}, 32'h1);
        check("reset_intr", {31'h0, INTR}, 32'h0);

        // 2: single byte 0xA5
        bus_write(BASE, 32'hA5, 1'b0);
        frame_check("a5", 10'b11_0100_1010);

        // 3: fill, overrun, flushed clear, real clear
        for (int i = 0; i < 9; i++) bus_write(BASE, 32'h10 + 32'(i), 1'b0);
        bus_read(BASE, d);
        check("fill_count", d, 32'h8);
        bus_read(CTRL, d);
        check("fill_tctrl", d, 32'h000);
        bus_write(BASE, 32'hEE, 1'b0);
        bus_read(CTRL, d);
        check("ovr_set", d, 32'h004);
        bus_write(CTRL, 32'h000, 1'b1);
        bus_read(CTRL, d);
        check("ovr_flush_clear", d, 32'h004);
        bus_write(CTRL, 32'h004, 1'b0);
        bus_read(CTRL, d);
        check("ovr_write1_keep", d, 32'h004);
        bus_write(CTRL, 32'h000, 1'b0);
        bus_read(CTRL, d);
        check("ovr_clear", d, 32'h000);
        repeat (400) next_cycle();
        bus_read(CTRL, d);
        check("drain_idle", d, 32'h003);

        // 4: flushed writes have no effect
        bus_write(BASE, 32'h55, 1'b1);
        bus_read(BASE, d);
        check("flush_count", d, 32'h0);
        repeat (5) next_cycle();
        check("flush_txd", {31'h0, TXD}, 32'h1);
        bus_write(CTRL, 32'h100, 1'b1);
        bus_read(CTRL, d);
        check("flush_ie", d, 32'h003);
        next_cycle();
        check("flush_intr", {31'h0, INTR}, 32'h0);

        // 5: interrupt follows ready with one edge of delay
        bus_write(CTRL, 32'h104, 1'b0);
        check("ie_intr_lag", {31'h0, INTR}, 32'h0);
        next_cycle();
        check("ie_intr_rise", {31'h0, INTR}, 32'h1);
        for (int i = 0; i < 9; i++) bus_write(BASE, 32'h60 + 32'(i), 1'b0);
        check("full_intr_lag", {31'h0, INTR}, 32'h1);
        next_cycle();
        check("full_intr_drop", {31'h0, INTR}, 32'h0);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            next_cycle();
            bus_read(BASE, d);
            if (d < 32'h8) seen = 1'b1;
        end
        check("pop_seen", {31'h0, seen}, 32'h1);
        check("pop_intr_lag", {31'h0, INTR}, 32'h0);
        next_cycle();
        check("pop_intr_rise", {31'h0, INTR}, 32'h1);
        repeat (400) next_cycle();
        bus_read(CTRL, d);
        check("ie_drain_idle", d, 32'h103);

        // 6: reset mid-frame, then a clean frame
        bus_write(BASE, 32'hC3, 1'b0);
        bus_write(BASE, 32'h3C, 1'b0);
        repeat (9) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("midreset_txd", {31'h0, TXD}, 32'h1);
        check("midreset_intr", {31'h0, INTR}, 32'h0);
        bus_read(BASE, d);
        check("midreset_count", d, 32'h0);
        bus_read(CTRL, d);
        check("midreset_tctrl", d, 32'h003);
        repeat (3) next_cycle();
        bus_write(BASE, 32'h5A, 1'b0);
        frame_check("5a", 10'b10_1011_0100);

        repeat (3) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
